// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Register select values (dataadr[3:2])
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output. A push into a
// full FIFO is still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS
// reports FIFO/serializer state, and a four-state FSM drives the tx line.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic [1:0]            sel;
  logic                  wr_en;
  logic                  push;
  logic                  ovf_clr;
  logic                  overflow;
  logic [7:0]            fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_pop;
  logic [ST_COUNT_W-1:0] count_field;
  logic [31:0]           status;
  logic                  unused_bits;

  tx_state_t             state, state_n;
  logic [BW-1:0]         baud_cnt, baud_n;
  logic [2:0]            bit_cnt, bit_n;
  logic [7:0]            shift, shift_n;
  logic                  baud_last;

  assign hit         = (dataadr[31:4] == BASE_ADDR[31:4]);
  assign sel         = dataadr[3:2];
  assign wr_en       = memwrite & hit;
  assign push        = wr_en & (sel == OFF_TXDATA);
  assign ovf_clr     = wr_en & (sel == OFF_STATUS) & writedata[3];
  assign count_field = ST_COUNT_W'(fifo_count);
  assign baud_last   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign unused_bits = ^{writedata[31:8], dataadr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (writedata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Sticky overflow: a dropped byte outranks a same-edge clear
  always_ff @(posedge clk) begin
    if (reset)                               overflow <= 1'b0;
    else if (push & fifo_full & ~fifo_pop)   overflow <= 1'b1;
    else if (ovf_clr)                        overflow <= 1'b0;
  end

  // STATUS word assembly and load-data mux
  always_comb begin
    status                                   = '0;
    status[ST_EMPTY]                         = fifo_empty;
    status[ST_FULL]                          = fifo_full;
    status[ST_BUSY]                          = (state != IDLE);
    status[ST_OVERFLOW]                      = overflow;
    status[ST_COUNT_LSB +: ST_COUNT_W]       = count_field;
    readdata                                 = '0;
    if (hit && sel == OFF_STATUS) readdata = status;
  end

  // Serializer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  end

  // Serializer next-state, FIFO pop and line level
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    fifo_pop = 1'b0;
    tx       = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_dout;
          baud_n   = '0;
          state_n  = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        tx = shift[0];
        if (baud_last) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_n   = bit_cnt + 3'd1;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          // Chain straight into the next frame when a byte is waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_dout;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the processor's data-memory bus (memwrite, dataadr, writedata, readdata) alongside dmem. Software stores bytes to a data register; the block queues them in a small FIFO and serializes them as 8N1 frames on `tx`. A status register reports FIFO and serializer state on loads, and `hit` lets the top level select this block's readdata over dmem's.

## Interface
- BASE_ADDR, 32'h0000_0080, base of the 16-byte register window; bits [3:0] must be zero.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, 4, number of byte entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memwrite  input  1  store strobe from the processor.
- dataadr  input  32  byte address from the processor.
- writedata  input  32  store data.
- readdata  output  32  load data; combinational from dataadr.
- hit  output  1  dataadr lies in the window; combinational.
- tx  output  1  serial line, idle high.

## Operation
- Decode: hit = (dataadr[31:4] == BASE_ADDR[31:4]). Register select is dataadr[3:2]. dataadr[1:0] is ignored.
- Offset 0x0 TXDATA:
  - Store with hit pushes writedata[7:0]; writedata[31:8] is ignored.
  - Load returns 0.
- Offset 0x4 STATUS, read: bit0 empty, bit1 full, bit2 busy (serializer not IDLE), bit3 overflow (sticky), bits[7:4] FIFO count (zero-extended), other bits 0.
- Offset 0x4 STATUS, store: writedata[3]=1 clears overflow; other bits are ignored.
- Offsets 0x8 and 0xC: loads return 0; stores are ignored.
- When hit=0, readdata = 0.
- Push while full:
  - If a pop happens on the same edge, the push is accepted.
  - Otherwise the byte is dropped and overflow is set.
- Simultaneous push and pop on a non-full FIFO: count is unchanged; both take effect.
- Serializer FSM states: IDLE, START, DATA, STOP. Bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is not empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Reset values:
  - FSM IDLE, tx=1.
  - FIFO empty; pointers, count and all counters 0.
  - overflow 0; shift register 0.
  - readdata and hit follow dataadr only.
- Reset mid-frame: the frame is abandoned, tx=1 from the next edge, and queued bytes are discarded.

## Timing
- Store to TXDATA on edge k with an empty FIFO and IDLE FSM: the FIFO holds the byte after edge k. The FSM pops on edge k+1, and tx=0 from edge k+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles: start bit, 8 data bits, stop bit.
- Back-to-back queued bytes go out with no gap between one frame's stop bit and the next frame's start bit.
- STATUS reflects register state as of the last edge; a push on edge k is visible in count after edge k.
- No backpressure to the processor: stores always complete in one cycle, and software polls full.

## Structure
- Package mmio_uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  - localparams OFF_TXDATA = 2'd0, OFF_STATUS = 2'd1;
  - STATUS bit-index constants.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports clk, reset, push, din, pop, dout, empty, full, count.
  - First-word-fall-through dout; same-edge push and pop allowed when full.
- Top of block: address decode, STATUS mux, overflow flop, serializer FSM.

## Test plan
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x80.
- Reset, then idle for 20 cycles: tx=1 throughout; load 0x84 returns 0x00000001.
- Store 0x000000A5 to 0x80: tx=0 from the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1; busy=1 during the frame; total 40 cycles.
- Store 0x41, 0x42, 0x43 on consecutive cycles: three contiguous frames with no idle cycles between them; STATUS count reads 2, 1, 0 as each byte is popped.
- Six stores with no waiting:
  - First is popped immediately, next four fill the FIFO, sixth is dropped.
  - STATUS reads full=1, overflow=1.
  - Store 0x8 to 0x84: overflow=0 while full stays 1.
  - Exactly 5 frames are emitted.
- Full FIFO, with the store coinciding with the end-of-STOP pop edge: the byte is accepted and overflow stays 0.
- Assert reset during bit 3 of a frame with 2 bytes queued:
  - tx=1 from the next edge.
  - STATUS reads 0x00000001.
  - No further frames unless new stores occur.
